// File: rtl/rs_multi_wb_pkg.sv
// Shared defaults and packed-op field layout for the multi-writeback ALU reservation station.
package rs_multi_wb_pkg;
  localparam int ROB_W_DEF    = 4;
  localparam int RS_DEPTH_DEF = 8;

  // ALU op = {L1 class, L2 function}; the station treats it as opaque.
  localparam int OP_L1_W  = 2;
  localparam int OP_L2_W  = 3;
  localparam int OP_W_DEF = OP_L1_W + OP_L2_W;

  typedef struct packed {
    logic [OP_L1_W-1:0] l1;
    logic [OP_L2_W-1:0] l2;
  } alu_op_t;
endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: older_q[j][i] means entry j was allocated before entry i; yields the oldest ready entry.
module rs_age_matrix #(
  parameter int N = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [N-1:0] alloc_in,
  input  logic [N-1:0] free_in,
  input  logic [N-1:0] ready_in,
  output logic [N-1:0] oldest_out
);
  logic [N-1:0] older_q [N];
  logic [N-1:0] older_d [N];
  logic [N-1:0] blocked;

  // A new entry clears its own row and becomes younger than every other slot;
  // stale rows of free slots never matter because only ready entries are compared.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < N; i++) begin
      if (free_in[i]) older_d[i] = '0;
    end
    for (int a = 0; a < N; a++) begin
      if (alloc_in[a]) begin
        older_d[a] = '0;
        for (int j = 0; j < N; j++) begin
          if (j != a) older_d[j][a] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    blocked = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        blocked[i] = blocked[i] | (ready_in[j] & older_q[j][i]);
      end
    end
    oldest_out = ready_in & ~blocked;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) older_q <= '{default: '0};
    else        older_q <= older_d;
  end
endmodule

// File: rtl/rs_multi_wb.sv
// ALU reservation station with NUM_WB writeback channels, dispatch bypass and age-ordered issue.
module rs_multi_wb
  import rs_multi_wb_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int ROB_W    = ROB_W_DEF,
  parameter int NUM_WB   = 2,
  parameter int OP_W     = OP_W_DEF,
  parameter int CNT_W    = $clog2(RS_DEPTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  disp_valid_in,
  input  logic [OP_W-1:0]       disp_op_in,
  input  logic [31:0]           disp_v1_in,
  input  logic [31:0]           disp_v2_in,
  input  logic [ROB_W-1:0]      disp_q1_in,
  input  logic [ROB_W-1:0]      disp_q2_in,
  input  logic                  disp_q1_busy_in,
  input  logic                  disp_q2_busy_in,
  input  logic [ROB_W-1:0]      disp_rob_id_in,
  input  logic [NUM_WB-1:0]     wb_valid_in,
  input  logic [NUM_WB*ROB_W-1:0] wb_tag_in,
  input  logic [NUM_WB*32-1:0]  wb_value_in,
  input  logic                  iss_ready_in,
  output logic                  iss_valid_out,
  output logic [OP_W-1:0]       iss_op_out,
  output logic [31:0]           iss_opr1_out,
  output logic [31:0]           iss_opr2_out,
  output logic [ROB_W-1:0]      iss_rob_id_out,
  output logic                  full_out,
  output logic [CNT_W-1:0]      count_out
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RS_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(RS_DEPTH);

  logic [RS_DEPTH-1:0] valid_q, valid_d;
  logic [OP_W-1:0]     op_q  [RS_DEPTH];
  logic [OP_W-1:0]     op_d  [RS_DEPTH];
  logic [31:0]         v1_q  [RS_DEPTH];
  logic [31:0]         v1_d  [RS_DEPTH];
  logic [31:0]         v2_q  [RS_DEPTH];
  logic [31:0]         v2_d  [RS_DEPTH];
  logic [ROB_W-1:0]    q1_q  [RS_DEPTH];
  logic [ROB_W-1:0]    q1_d  [RS_DEPTH];
  logic [ROB_W-1:0]    q2_q  [RS_DEPTH];
  logic [ROB_W-1:0]    q2_d  [RS_DEPTH];
  logic [ROB_W-1:0]    rob_q [RS_DEPTH];
  logic [ROB_W-1:0]    rob_d [RS_DEPTH];
  logic [RS_DEPTH-1:0] b1_q, b1_d, b2_q, b2_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                iss_valid_q;
  logic [OP_W-1:0]     iss_op_q;
  logic [31:0]         iss_opr1_q, iss_opr2_q;
  logic [ROB_W-1:0]    iss_rob_q;

  logic [RS_DEPTH-1:0] ready, oldest, free_slot, alloc_vec, free_vec;
  logic                accept, issue, flush_now, slot_found;
  logic [31:0]         disp_v1, disp_v2;
  logic                disp_b1, disp_b2;
  logic [OP_W-1:0]     sel_op;
  logic [31:0]         sel_v1, sel_v2;
  logic [ROB_W-1:0]    sel_rob;

  assign ready     = valid_q & ~b1_q & ~b2_q;
  assign flush_now = rdy_in & flush_in;
  assign accept    = rdy_in & ~flush_in & disp_valid_in & (count_q != DEPTH_C);
  assign issue     = rdy_in & ~flush_in & iss_ready_in & (|ready);
  assign alloc_vec = accept ? free_slot : '0;
  assign free_vec  = flush_now ? '1 : (issue ? oldest : '0);

  rs_age_matrix #(.N(RS_DEPTH)) u_age (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .alloc_in  (alloc_vec),
    .free_in   (free_vec),
    .ready_in  (ready),
    .oldest_out(oldest)
  );

  always_comb begin
    free_slot  = '0;
    slot_found = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!valid_q[i] && !slot_found) begin
        free_slot[i] = 1'b1;
        slot_found   = 1'b1;
      end
    end
  end

  // Channels are scanned high-to-low so the lowest matching channel is written last and wins.
  always_comb begin
    disp_v1 = disp_v1_in;
    disp_v2 = disp_v2_in;
    disp_b1 = disp_q1_busy_in;
    disp_b2 = disp_q2_busy_in;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (disp_q1_busy_in && wb_valid_in[k] && wb_tag_in[k*ROB_W +: ROB_W] == disp_q1_in) begin
        disp_v1 = wb_value_in[k*32 +: 32];
        disp_b1 = 1'b0;
      end
      if (disp_q2_busy_in && wb_valid_in[k] && wb_tag_in[k*ROB_W +: ROB_W] == disp_q2_in) begin
        disp_v2 = wb_value_in[k*32 +: 32];
        disp_b2 = 1'b0;
      end
    end
  end

  always_comb begin
    op_d  = op_q;
    v1_d  = v1_q;
    v2_d  = v2_q;
    q1_d  = q1_q;
    q2_d  = q2_q;
    rob_d = rob_q;
    b1_d  = b1_q;
    b2_d  = b2_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (alloc_vec[i]) begin
        op_d[i]  = disp_op_in;
        v1_d[i]  = disp_v1;
        v2_d[i]  = disp_v2;
        q1_d[i]  = disp_q1_in;
        q2_d[i]  = disp_q2_in;
        rob_d[i] = disp_rob_id_in;
        b1_d[i]  = disp_b1;
        b2_d[i]  = disp_b2;
      end else if (valid_q[i]) begin
        for (int k = NUM_WB - 1; k >= 0; k--) begin
          if (b1_q[i] && wb_valid_in[k] && wb_tag_in[k*ROB_W +: ROB_W] == q1_q[i]) begin
            v1_d[i] = wb_value_in[k*32 +: 32];
            b1_d[i] = 1'b0;
          end
          if (b2_q[i] && wb_valid_in[k] && wb_tag_in[k*ROB_W +: ROB_W] == q2_q[i]) begin
            v2_d[i] = wb_value_in[k*32 +: 32];
            b2_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    sel_op  = '0;
    sel_v1  = '0;
    sel_v2  = '0;
    sel_rob = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (oldest[i]) begin
        sel_op  = sel_op  | op_q[i];
        sel_v1  = sel_v1  | v1_q[i];
        sel_v2  = sel_v2  | v2_q[i];
        sel_rob = sel_rob | rob_q[i];
      end
    end
  end

  always_comb begin
    if (flush_now) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      valid_d = (valid_q & ~free_vec) | alloc_vec;
      count_d = count_q + CNT_W'(accept) - CNT_W'(issue);
    end
  end

  // Payload storage carries no reset: an invalid entry's contents are never observed.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      op_q  <= op_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      q1_q  <= q1_d;
      q2_q  <= q2_d;
      rob_q <= rob_d;
      b1_q  <= b1_d;
      b2_q  <= b2_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q     <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_opr1_q  <= '0;
      iss_opr2_q  <= '0;
      iss_rob_q   <= '0;
    end else if (rdy_in) begin
      valid_q     <= valid_d;
      count_q     <= count_d;
      iss_valid_q <= issue;
      if (issue) begin
        iss_op_q   <= sel_op;
        iss_opr1_q <= sel_v1;
        iss_opr2_q <= sel_v2;
        iss_rob_q  <= sel_rob;
      end
    end
  end

  assign iss_valid_out  = iss_valid_q;
  assign iss_op_out     = iss_op_q;
  assign iss_opr1_out   = iss_opr1_q;
  assign iss_opr2_out   = iss_opr2_q;
  assign iss_rob_id_out = iss_rob_q;
  assign count_out      = count_q;
  assign full_out       = ({1'b0, count_q} + {{CNT_W{1'b0}}, disp_valid_in}) >= DEPTH_X;

  a_no_disp_when_full: assert property (@(posedge clk_in) disable iff (rst_in)
    !(rdy_in && !flush_in && disp_valid_in && count_q == DEPTH_C));
endmodule

// File: tb/tb_rs_multi_wb.sv
// Directed bench for rs_multi_wb: age order, wakeup, bypass, full, flush, rdy hold and async reset.
module tb_rs_multi_wb;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        disp_valid_in;
  logic [4:0]  disp_op_in;
  logic [31:0] disp_v1_in, disp_v2_in;
  logic [3:0]  disp_q1_in, disp_q2_in;
  logic        disp_q1_busy_in, disp_q2_busy_in;
  logic [3:0]  disp_rob_id_in;
  logic [1:0]  wb_valid_in;
  logic [7:0]  wb_tag_in;
  logic [63:0] wb_value_in;
  logic        iss_ready_in;
  logic        iss_valid_out;
  logic [4:0]  iss_op_out;
  logic [31:0] iss_opr1_out, iss_opr2_out;
  logic [3:0]  iss_rob_id_out;
  logic        full_out;
  logic [3:0]  count_out;

  int n_checks = 0;
  int n_fail   = 0;

  rs_multi_wb dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid_in(disp_valid_in), .disp_op_in(disp_op_in),
    .disp_v1_in(disp_v1_in), .disp_v2_in(disp_v2_in),
    .disp_q1_in(disp_q1_in), .disp_q2_in(disp_q2_in),
    .disp_q1_busy_in(disp_q1_busy_in), .disp_q2_busy_in(disp_q2_busy_in),
    .disp_rob_id_in(disp_rob_id_in),
    .wb_valid_in(wb_valid_in), .wb_tag_in(wb_tag_in), .wb_value_in(wb_value_in),
    .iss_ready_in(iss_ready_in), .iss_valid_out(iss_valid_out), .iss_op_out(iss_op_out),
    .iss_opr1_out(iss_opr1_out), .iss_opr2_out(iss_opr2_out),
    .iss_rob_id_out(iss_rob_id_out), .full_out(full_out), .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic set_disp(input logic [3:0] rob, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [3:0] q1, input logic b1, input logic [3:0] q2, input logic b2);
    disp_valid_in   = 1'b1;
    disp_op_in      = 5'(rob) ^ 5'h15;
    disp_rob_id_in  = rob;
    disp_v1_in      = v1;
    disp_v2_in      = v2;
    disp_q1_in      = q1;
    disp_q1_busy_in = b1;
    disp_q2_in      = q2;
    disp_q2_busy_in = b2;
  endtask

  task automatic idle_inputs();
    disp_valid_in = 1'b0; disp_op_in = '0; disp_v1_in = '0; disp_v2_in = '0;
    disp_q1_in = '0; disp_q2_in = '0; disp_q1_busy_in = 1'b0; disp_q2_busy_in = 1'b0;
    disp_rob_id_in = '0; wb_valid_in = '0; wb_tag_in = '0; wb_value_in = '0;
    iss_ready_in = 1'b0; flush_in = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle_inputs();
    cyc();
    n_checks++; if (iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %0h want 0", iss_valid_out); end
    n_checks++; if (count_out !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_out); end
    n_checks++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0h want 0", full_out); end
    n_checks++; if (iss_rob_id_out !== 4'd0) begin n_fail++; $display("FAIL reset_iss_rob: got %0h want 0", iss_rob_id_out); end
    rst_in = 1'b0;
    cyc();
  endtask

  // rob 8 occupies entry 0 and issues first; rob 2 then refills entry 0 but is youngest.
  task automatic test_age_order();
    set_disp(4'd8, 32'h80, 32'h0, 4'd0, 1'b0, 4'd0, 1'b0);
    cyc();
    n_checks++; if (count_out !== 4'd1) begin n_fail++; $display("FAIL age_count1: got %0d want 1", count_out); end
    set_disp(4'd3, 32'h30, 32'h3, 4'd0, 1'b0, 4'd0, 1'b0);
    cyc();
    set_disp(4'd1, 32'h10, 32'h1, 4'd0, 1'b0, 4'd0, 1'b0);
    iss_ready_in = 1'b1;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || iss_rob_id_out !== 4'd8) begin n_fail++; $display("FAIL age_first: got v=%0h rob=%0d want v=1 rob=8", iss_valid_out, iss_rob_id_out); end
    set_disp(4'd2, 32'h20, 32'h2, 4'd0, 1'b0, 4'd0, 1'b0);
    iss_ready_in = 1'b0;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b0 || count_out !== 4'd3) begin n_fail++; $display("FAIL age_hold: got v=%0h cnt=%0d want v=0 cnt=3", iss_valid_out, count_out); end
    disp_valid_in = 1'b0;
    iss_ready_in  = 1'b1;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || iss_rob_id_out !== 4'd3 || iss_opr1_out !== 32'h30) begin n_fail++; $display("FAIL age_rob3: got v=%0h rob=%0d opr1=%0h want v=1 rob=3 opr1=30", iss_valid_out, iss_rob_id_out, iss_opr1_out); end
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || iss_rob_id_out !== 4'd1 || iss_op_out !== 5'h14) begin n_fail++; $display("FAIL age_rob1: got v=%0h rob=%0d op=%0h want v=1 rob=1 op=14", iss_valid_out, iss_rob_id_out, iss_op_out); end
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || iss_rob_id_out !== 4'd2 || iss_opr2_out !== 32'h2) begin n_fail++; $display("FAIL age_rob2: got v=%0h rob=%0d opr2=%0h want v=1 rob=2 opr2=2", iss_valid_out, iss_rob_id_out, iss_opr2_out); end
    n_checks++; if (count_out !== 4'd0) begin n_fail++; $display("FAIL age_count_end: got %0d want 0", count_out); end
    iss_ready_in = 1'b0;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b0 || iss_rob_id_out !== 4'd2) begin n_fail++; $display("FAIL age_pulse_end: got v=%0h rob=%0d want v=0 rob=2", iss_valid_out, iss_rob_id_out); end
  endtask

  task automatic test_multi_wakeup();
    set_disp(4'd5, 32'hDEAD, 32'hBEEF, 4'd2, 1'b1, 4'd7, 1'b1);
    iss_ready_in = 1'b1;
    cyc();
    disp_valid_in = 1'b0;
    wb_valid_in = 2'b11; wb_tag_in = {4'd7, 4'd2}; wb_value_in = {32'h22, 32'h11};
    cyc();
    n_checks++; if (iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL mwake_early: got %0h want 0", iss_valid_out); end
    wb_valid_in = 2'b00;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || iss_rob_id_out !== 4'd5 || iss_opr1_out !== 32'h11 || iss_opr2_out !== 32'h22) begin
      n_fail++; $display("FAIL mwake_issue: got v=%0h rob=%0d o1=%0h o2=%0h want v=1 rob=5 o1=11 o2=22", iss_valid_out, iss_rob_id_out, iss_opr1_out, iss_opr2_out); end
    iss_ready_in = 1'b0;
    cyc();
  endtask

  // Both channels carry tag 6: channel 0 must win, and it wakes both operands.
  task automatic test_wakeup_priority();
    set_disp(4'd10, 32'h0, 32'h0, 4'd6, 1'b1, 4'd6, 1'b1);
    iss_ready_in = 1'b1;
    cyc();
    disp_valid_in = 1'b0;
    wb_valid_in = 2'b11; wb_tag_in = {4'd6, 4'd6}; wb_value_in = {32'h44, 32'h33};
    cyc();
    wb_valid_in = 2'b00;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || iss_rob_id_out !== 4'd10 || iss_opr1_out !== 32'h33 || iss_opr2_out !== 32'h33) begin
      n_fail++; $display("FAIL wake_prio: got v=%0h rob=%0d o1=%0h o2=%0h want v=1 rob=10 o1=33 o2=33", iss_valid_out, iss_rob_id_out, iss_opr1_out, iss_opr2_out); end
    iss_ready_in = 1'b0;
    cyc();
  endtask

  task automatic test_dispatch_bypass();
    set_disp(4'd12, 32'h0, 32'h99, 4'd4, 1'b1, 4'd0, 1'b0);
    wb_valid_in = 2'b10; wb_tag_in = {4'd4, 4'd4}; wb_value_in = {32'hABCD, 32'hDEAD};
    iss_ready_in = 1'b1;
    cyc();
    disp_valid_in = 1'b0;
    wb_valid_in = 2'b00;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || iss_rob_id_out !== 4'd12 || iss_opr1_out !== 32'hABCD || iss_opr2_out !== 32'h99) begin
      n_fail++; $display("FAIL bypass_issue: got v=%0h rob=%0d o1=%0h o2=%0h want v=1 rob=12 o1=abcd o2=99", iss_valid_out, iss_rob_id_out, iss_opr1_out, iss_opr2_out); end
    iss_ready_in = 1'b0;
    cyc();
  endtask

  task automatic test_full_backpressure();
    iss_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_disp(4'(i), 32'h100 + 32'(i), 32'h0, 4'd0, 1'b0, 4'd0, 1'b0);
      #1;
      n_checks++; if (full_out !== (i == 7) || count_out !== 4'(i)) begin
        n_fail++; $display("FAIL full_fill%0d: got full=%0h cnt=%0d want full=%0h cnt=%0d", i, full_out, count_out, (i == 7), i); end
      cyc();
    end
    disp_valid_in = 1'b0;
    #1;
    n_checks++; if (count_out !== 4'd8 || full_out !== 1'b1) begin n_fail++; $display("FAIL full_at8: got cnt=%0d full=%0h want cnt=8 full=1", count_out, full_out); end
    iss_ready_in = 1'b1;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || iss_rob_id_out !== 4'd0 || iss_opr1_out !== 32'h100 || count_out !== 4'd7) begin
      n_fail++; $display("FAIL full_drain: got v=%0h rob=%0d o1=%0h cnt=%0d want v=1 rob=0 o1=100 cnt=7", iss_valid_out, iss_rob_id_out, iss_opr1_out, count_out); end
    iss_ready_in = 1'b0;
    #1;
    n_checks++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL full_after_drain: got %0h want 0", full_out); end
  endtask

  // Seven ready entries remain from the previous task.
  task automatic test_flush_collision();
    flush_in = 1'b1;
    set_disp(4'd13, 32'h0, 32'h0, 4'd3, 1'b1, 4'd0, 1'b0);
    wb_valid_in = 2'b01; wb_tag_in = {4'd0, 4'd3}; wb_value_in = {32'h0, 32'h77};
    iss_ready_in = 1'b1;
    cyc();
    n_checks++; if (count_out !== 4'd0 || iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_state: got cnt=%0d v=%0h want cnt=0 v=0", count_out, iss_valid_out); end
    flush_in = 1'b0;
    wb_valid_in = 2'b00;
    iss_ready_in = 1'b0;
    set_disp(4'd14, 32'h1414, 32'h0, 4'd0, 1'b0, 4'd0, 1'b0);
    cyc();
    n_checks++; if (count_out !== 4'd1 || dut.valid_q !== 8'h01) begin n_fail++; $display("FAIL flush_realloc: got cnt=%0d valid=%0h want cnt=1 valid=01", count_out, dut.valid_q); end
    disp_valid_in = 1'b0;
    iss_ready_in = 1'b1;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || iss_rob_id_out !== 4'd14 || iss_opr1_out !== 32'h1414) begin
      n_fail++; $display("FAIL flush_next_issue: got v=%0h rob=%0d o1=%0h want v=1 rob=14 o1=1414", iss_valid_out, iss_rob_id_out, iss_opr1_out); end
    iss_ready_in = 1'b0;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b0 || count_out !== 4'd0) begin n_fail++; $display("FAIL flush_empty: got v=%0h cnt=%0d want v=0 cnt=0", iss_valid_out, count_out); end
  endtask

  task automatic test_rdy_hold();
    set_disp(4'd9, 32'h90, 32'h9, 4'd0, 1'b0, 4'd0, 1'b0);
    iss_ready_in = 1'b1;
    cyc();
    disp_valid_in = 1'b0;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || iss_rob_id_out !== 4'd9) begin n_fail++; $display("FAIL rdy_issue: got v=%0h rob=%0d want v=1 rob=9", iss_valid_out, iss_rob_id_out); end
    rdy_in = 1'b0;
    set_disp(4'd11, 32'hB0, 32'hB, 4'd0, 1'b0, 4'd0, 1'b0);
    cyc();
    n_checks++; if (iss_valid_out !== 1'b1 || count_out !== 4'd0) begin n_fail++; $display("FAIL rdy_freeze: got v=%0h cnt=%0d want v=1 cnt=0", iss_valid_out, count_out); end
    rdy_in = 1'b1;
    disp_valid_in = 1'b0;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b0 || count_out !== 4'd0) begin n_fail++; $display("FAIL rdy_resume: got v=%0h cnt=%0d want v=0 cnt=0", iss_valid_out, count_out); end
    iss_ready_in = 1'b0;
  endtask

  // Reset lands 2ns after the edge that raised an issue pulse and one entry is still queued.
  task automatic test_reset_midrun();
    set_disp(4'd7, 32'h70, 32'h7, 4'd0, 1'b0, 4'd0, 1'b0);
    iss_ready_in = 1'b1;
    cyc();
    set_disp(4'd6, 32'h60, 32'h6, 4'd0, 1'b0, 4'd0, 1'b0);
    iss_ready_in = 1'b0;
    cyc();
    disp_valid_in = 1'b0;
    iss_ready_in = 1'b1;
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    n_checks++; if (iss_valid_out !== 1'b0 || count_out !== 4'd0 || full_out !== 1'b0 || iss_rob_id_out !== 4'd0) begin
      n_fail++; $display("FAIL reset_midrun: got v=%0h cnt=%0d full=%0h rob=%0d want 0 0 0 0", iss_valid_out, count_out, full_out, iss_rob_id_out); end
    cyc();
    rst_in = 1'b0;
    cyc();
    n_checks++; if (iss_valid_out !== 1'b0 || count_out !== 4'd0) begin n_fail++; $display("FAIL reset_after: got v=%0h cnt=%0d want v=0 cnt=0", iss_valid_out, count_out); end
    iss_ready_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_age_order();
    test_multi_wakeup();
    test_wakeup_priority();
    test_dispatch_bypass();
    test_full_backpressure();
    test_flush_collision();
    test_rdy_hold();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_multi_wb.md
# rs_multi_wb

Parametrised ALU reservation station, successor to the single-ALU/single-memory-bus station. It holds decoded ALU ops between the decoder and the ALU, captures operands from `NUM_WB` writeback channels, and issues the oldest ready entry each cycle under ALU backpressure. Operand readiness uses explicit busy bits rather than an all-ones tag, so every ROB index is a legal tag.

## Interface
- `RS_DEPTH`, 8: entry count, ≥2.
- `ROB_W`, 4: ROB index width.
- `NUM_WB`, 2: writeback channels, ≥1.
- `OP_W`, 5: opaque ALU op width (L1 and L2 fields packed).
- `CNT_W`, `$clog2(RS_DEPTH+1)`: derived occupancy width.

- `clk_in` in 1: clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `rdy_in` in 1: global enable; when low, all state and outputs hold.
- `flush_in` in 1: mispredict flush.
- `disp_valid_in` in 1: dispatch request.
- `disp_op_in` in `OP_W`: op.
- `disp_v1_in`, `disp_v2_in` in 32: operand values, used when not busy.
- `disp_q1_in`, `disp_q2_in` in `ROB_W`: producer tags.
- `disp_q1_busy_in`, `disp_q2_busy_in` in 1: operand still pending.
- `disp_rob_id_in` in `ROB_W`: destination ROB index.
- `wb_valid_in` in `NUM_WB`: per-channel broadcast valid.
- `wb_tag_in` in `NUM_WB*ROB_W`: packed tags; channel k is at `[k*ROB_W +: ROB_W]`.
- `wb_value_in` in `NUM_WB*32`: packed values.
- `iss_ready_in` in 1: ALU can accept an issue this cycle.
- `iss_valid_out` out 1: registered issue pulse.
- `iss_op_out` out `OP_W`, `iss_opr1_out` out 32, `iss_opr2_out` out 32, `iss_rob_id_out` out `ROB_W`: issued entry.
- `full_out` out 1: combinational; `count + disp_valid_in >= RS_DEPTH`.
- `count_out` out `CNT_W`: registered occupancy.

## Operation
- **Entry contents:** valid, op, v1, v2, q1, q2, q1_busy, q2_busy, rob_id.
- **Age tracking:** an age matrix, `older[i][j]`, set when an entry is allocated.
- **Allocation:**
  - On `disp_valid_in`, write the lowest-index free entry.
  - The new entry is younger than every valid entry.
  - Dispatch when `count == RS_DEPTH` is illegal: drop it and fire an assertion.
- **Dispatch bypass:** if an operand is busy and some `wb_valid_in[k]` carries a matching tag this cycle, store `wb_value[k]` with busy=0. When several channels match, the lowest k wins.
- **Wakeup:** each valid entry compares both tags against all valid channels. On a match it captures the value and clears busy (lowest k wins). A channel matching both operands wakes both.
- **Select:**
  - Ready means valid with both busy bits clear.
  - When `iss_ready_in=1`, pick the ready entry with no older ready entry, register its fields onto `iss_*`, set `iss_valid_out=1`, and free the entry.
  - Otherwise `iss_valid_out <= 0`, and `iss_*` data outputs hold their last value.
  - Select reads registered state only: wakeups this cycle do not affect this cycle's select.
- **Count:** `count += disp_accepted − issued`. A slot freed by issue is not reallocated in the same cycle.
- **Flush** (while `rdy_in=1`): all entries invalid, count=0, `iss_valid_out<=0`. Flush overrides simultaneous dispatch, wakeup and issue.
- **Reset:** all entries invalid, age matrix cleared, count 0, `iss_valid_out` 0, all `iss_*` data 0.

## Timing
- Dispatch sampled at edge E0 with both operands ready (or bypassed): earliest `iss_valid_out=1` is after E1 (1-cycle latency).
- Wakeup at edge E: the entry is eligible at edge E+1; `iss_valid_out` rises after E+1.
- `iss_valid_out` is a one-cycle pulse per issue; back-to-back issues on consecutive cycles are allowed.
- `full_out` ignores a same-cycle issue (conservative).
- `rdy_in=0` freezes everything, including `iss_valid_out` and flush; a held pulse is not re-counted by the ALU because ALU and RS share `rdy_in`.
- Asynchronous reset takes effect immediately mid-operation, including mid-issue.

## Structure
- Shared package/const header: `ROB_W` default, `RS_DEPTH` default, `OP_W`, and the packed-op field layout.
- One sub-module, `rs_age_matrix`, with these ports: alloc one-hot in, free one-hot in, ready vector in, oldest-ready one-hot out.
- Entry storage, wakeup comparators, free-slot priority encoder and count stay in `rs_multi_wb`.

## Test plan
- **Reset/idle:** assert `rst_in` mid-run → `iss_valid_out=0`, `count_out=0`, `full_out=0` immediately.
- **Age order:** dispatch three ready ops, rob 3, 1, 2, with `iss_ready_in=1` → issues rob 3, 1, 2 on consecutive cycles.
- **Multi-channel wakeup:** dispatch rob 5 with q1=2 busy and q2=7 busy. Next cycle drive ch0 tag 2 value 0x11 and ch1 tag 7 value 0x22 together → one cycle later issue rob 5, opr1=0x11, opr2=0x22.
- **Dispatch bypass:** dispatch with q1=4 busy while ch1 broadcasts tag 4 value 0xABCD → issue the next cycle with opr1=0xABCD.
- **Full/backpressure:** `RS_DEPTH=8`, `iss_ready_in=0`, dispatch 8 ready ops → `full_out=1` once count=7 with dispatch pending, and `count_out=8`. Raise `iss_ready_in` → oldest issues first, count drops to 7.
- **Flush collision:** `flush_in` together with dispatch, wakeup and a pending issue → `count_out=0`, no `iss_valid_out` the next cycle, and a later dispatch goes into entry 0.
